// File: rtl/gate_response_checker_if.sv
// Handshake/stimulus bundle between the gate checker and the gate under test.
// Optional fail_valid/fail_vec exist only with FIRST_FAIL_CAPTURE_EN.
interface gate_response_checker_if;
  logic       start;
  logic [2:0] gate_sel;
  logic       A;
  logic       B;
  logic       Z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       fail_valid;
  logic [1:0] fail_vec;

  modport master (
    input  start, gate_sel, Z,
    output A, B, busy, done, pass, err_count,
    output fail_valid, fail_vec
  );

  modport slave (
    output start, gate_sel, Z,
    input  A, B, busy, done, pass, err_count,
    input  fail_valid, fail_vec
  );
`else
  modport master (
    input  start, gate_sel, Z,
    output A, B, busy, done, pass, err_count
  );

  modport slave (
    output start, gate_sel, Z,
    input  A, B, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/gate_response_checker.sv
// Walks {A,B} through 00,10,01,11 and checks Z against the selected gate.
// Optional first-failure capture is built when FIRST_FAIL_CAPTURE_EN is defined.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  gate_response_checker_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

  state_t     state;
  logic [2:0] sel;
  logic [1:0] vec;
  logic [3:0] cnt;

  logic       expected;
  logic       miss;
  logic [2:0] err_next;
  logic [1:0] vec_next;

  always_comb begin
    expected = 1'b0;
    unique case (sel)
      3'd0: expected = bus.A & bus.B;
      3'd1: expected = bus.A | bus.B;
      3'd2: expected = ~(bus.A & bus.B);
      3'd3: expected = ~(bus.A | bus.B);
      3'd4: expected = bus.A ^ bus.B;
      3'd5: expected = ~(bus.A ^ bus.B);
      3'd6: expected = bus.A;
      3'd7: expected = ~bus.A;
    endcase
    miss     = bus.Z != expected;
    err_next = bus.err_count;
    if (miss && bus.err_count != 3'd4)
      err_next = bus.err_count + 3'd1;
    vec_next = vec + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= 3'd0;
      vec           <= 2'd0;
      cnt           <= 4'd0;
      bus.A         <= 1'b0;
      bus.B         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= 3'd0;
`ifdef FIRST_FAIL_CAPTURE_EN
      bus.fail_valid <= 1'b0;
      bus.fail_vec   <= 2'd0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sel           <= bus.gate_sel;
            vec           <= 2'd0;
            cnt           <= 4'd0;
            bus.A         <= 1'b0;
            bus.B         <= 1'b0;
            bus.busy      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
`ifdef FIRST_FAIL_CAPTURE_EN
            bus.fail_valid <= 1'b0;
            bus.fail_vec   <= 2'd0;
`endif
            state <= DRIVE;
          end
        end
        DRIVE: begin
          cnt   <= 4'd0;
          state <= NO_SETTLE ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST)
            state <= SAMPLE;
          else
            cnt <= cnt + 4'd1;
        end
        SAMPLE: begin
          bus.err_count <= err_next;
`ifdef FIRST_FAIL_CAPTURE_EN
          if (miss && !bus.fail_valid) begin
            bus.fail_valid <= 1'b1;
            bus.fail_vec   <= {bus.A, bus.B};
          end
`endif
          if (vec == 2'd3) begin
            bus.done <= 1'b1;
            bus.pass <= (err_next == 3'd0);
            state    <= DONE;
          end else begin
            // vector index bit 0 drives A, bit 1 drives B
            vec   <= vec_next;
            bus.A <= vec_next[0];
            bus.B <= vec_next[1];
            state <= DRIVE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          bus.A    <= 1'b0;
          bus.B    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, 2, number of clock cycles to wait between driving a vector and sampling Z; legal range 0..15.
REQ-002 Port: clk  input  1  single clock for all state; rising-edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  run request, sampled on the rising edge.
REQ-005 Port: gate_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF_A, 7 NOT_A.
REQ-006 Port: A  output  1  stimulus to gate under test (registered).
REQ-007 Port: B  output  1  stimulus to gate under test (registered).
REQ-008 Port: Z  input  1  response from gate under test.
REQ-009 Port: busy  output  1  high from the start-accept edge until the DONE state is left.
REQ-010 Port: done  output  1  one-cycle pulse at end of run.
REQ-011 Port: pass  output  1  1 when the last run had zero mismatches; held until the next start accept.
REQ-012 Port: err_count  output  3  mismatches in the last run, 0..4; held until the next start accept.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1 SHALL latch gate_sel, clear err_count and pass, set busy, drive vector 0, and go to DRIVE.
REQ-015 Vector order SHALL be {A,B} = 00, 10, 01, 11, indexed by a 2-bit counter.
REQ-016 DRIVE SHALL last 1 cycle, then SETTLE SHALL last SETTLE_CYCLES cycles, then SAMPLE SHALL last 1 cycle; with SETTLE_CYCLES=0, DRIVE SHALL go directly to SAMPLE.
REQ-017 On the edge leaving SAMPLE, Z SHALL be compared with the latched gate_sel function of the current A,B; a mismatch SHALL increment err_count.
REQ-018 After the SAMPLE of vectors 0-2, the FSM SHALL load the next vector into A,B and enter DRIVE; after vector 3 it SHALL enter DONE.
REQ-019 DONE SHALL last 1 cycle with done=1, pass=(err_count==0), busy=1; it SHALL then return to IDLE with busy=0 and A,B=0.
REQ-020 Latency: done SHALL be high after edge 4*(SETTLE_CYCLES+2) counted from the start-accept edge (edge 0), i.e. 16 for the default.
REQ-021 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-022 gate_sel changes after the start-accept edge SHALL NOT affect the run in progress.
REQ-023 err_count SHALL NOT wrap; 4 is the maximum reachable value.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and A=0, B=0, busy=0, done=0, pass=0, err_count=0, and clear the vector and settle counters.
REQ-025 A reset during a run SHALL abort that run with no done pulse; the first start after rst_n deasserts SHALL run normally.

Configuration
REQ-026 Macro FIRST_FAIL_CAPTURE_EN defined: ports fail_valid (output 1) and fail_vec (output 2) SHALL exist; on the first mismatch of a run, fail_vec SHALL capture {A,B} and fail_valid SHALL be set; later mismatches SHALL NOT overwrite them; both SHALL clear on reset and on start accept.
REQ-027 Macro FIRST_FAIL_CAPTURE_EN undefined: fail_valid, fail_vec and their registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 gate_sel=1 with an ideal OR model on Z, start pulsed -> done at edge 16, pass=1, err_count=0, A/B sequence 00,10,01,11.
REQ-029 gate_sel=1 with Z tied 0 -> err_count=3, pass=0; with the macro defined, fail_valid=1 and fail_vec=2'b10.
REQ-030 gate_sel=4 (XOR) with Z=A|B -> err_count=1, pass=0; with the macro defined, fail_vec=2'b11.
REQ-031 start held high for the full run -> exactly one done pulse, with no restart during DONE; a run follows in the cycle after the return to IDLE.
REQ-032 rst_n pulsed low during vector 2 SETTLE -> all outputs 0 at once and no done; a subsequent start with the ideal OR model -> pass=1.
REQ-033 SETTLE_CYCLES=0, gate_sel=7 with Z=~A -> done at edge 8, pass=1.
